// File: rtl/hex_register_display.sv
// hex_register_display: DIGITS-nibble push-button register with shift/count modes and hex display.
// Define HEX_SATURATE_EN to make counting saturate instead of wrapping.
module hex_register_display #(
    parameter int DIGITS = 2
) (
    input  logic [1:0]          KEY,
    input  logic [9:0]          SW,
    output logic [9:0]          LEDR,
    output logic [7*DIGITS-1:0] HEX
);
    localparam int W = 4 * DIGITS;
`ifdef HEX_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk, rst_n, en, unused_sw;
    logic [1:0]   mode;
    logic [W-1:0] value_q, value_d;
    logic         flag_q, flag_d, all1, zero;

    assign clk       = KEY[0];
    assign rst_n     = KEY[1];
    assign en        = SW[9];
    assign mode      = SW[8:7];
    assign unused_sw = ^SW[6:4];
    assign all1      = &value_q;
    assign zero      = ~|value_q;

    always_comb begin
        value_d = value_q;
        flag_d  = flag_q;
        if (en && mode == 2'b01) begin
            value_d = W'({value_q, SW[3:0]});
            flag_d  = |value_q[W-1:W-4];
        end else if (en && mode == 2'b10) begin
            value_d = (SAT && all1) ? value_q : value_q + W'(1);
            flag_d  = all1;
        end else if (en && mode == 2'b11) begin
            value_d = (SAT && zero) ? value_q : value_q - W'(1);
            flag_d  = zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            flag_q  <= flag_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign LEDR[9] = flag_q;
    assign LEDR[8] = zero;

    generate
        if (W >= 8) begin : g_led_full
            assign LEDR[7:0] = value_q[7:0];
        end else begin : g_led_ext
            assign LEDR[7:0] = {{(8 - W){1'b0}}, value_q};
        end
        for (genvar i = 0; i < DIGITS; i++) begin : g_hex
            assign HEX[7*i +: 7] = seg7(value_q[4*i +: 4]);
        end
    endgenerate
endmodule

// File: tb/tb_hex_register_display.sv
// tb_hex_register_display: directed and random checks of hex_register_display (DIGITS=2) against an arithmetic model.
module tb_hex_register_display;
    logic [1:0]  KEY;
    logic [9:0]  SW;
    logic [9:0]  LEDR;
    logic [13:0] HEX;

    int checks = 0;
    int passed = 0;
    int mval   = 0;
    int mflg   = 0;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    hex_register_display #(.DIGITS(2)) dut (.KEY(KEY), .SW(SW), .LEDR(LEDR), .HEX(HEX));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference behaviour in plain integer arithmetic on the held value.
    task automatic model(input logic [9:0] s);
        int d, nv, nf;
        d  = int'(s[3:0]);
        nv = mval;
        nf = mflg;
        if (s[9]) begin
            case (s[8:7])
                2'b01: begin nf = (mval / 16) != 0; nv = (mval * 16 + d) % 256; end
                2'b10: begin
                    nf = (mval == 255);
`ifdef HEX_SATURATE_EN
                    nv = (mval == 255) ? 255 : mval + 1;
`else
                    nv = (mval + 1) % 256;
`endif
                end
                2'b11: begin
                    nf = (mval == 0);
`ifdef HEX_SATURATE_EN
                    nv = (mval == 0) ? 0 : mval - 1;
`else
                    nv = (mval + 255) % 256;
`endif
                end
                default: ;
            endcase
        end
        mval = nv;
        mflg = nf;
    endtask

    task automatic pulse(input logic [9:0] s);
        SW = s;
        #5 KEY[0] = 1'b1;
        model(s);
        #2 SW = 10'($urandom);
        #3 KEY[0] = 1'b0;
        #2;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ledr"}, 32'(LEDR), 32'({mflg[0], mval == 0, mval[7:0]}));
        check({tag, ".hex0"}, 32'(HEX[6:0]), 32'(seg_tab[mval % 16]));
        check({tag, ".hex1"}, 32'(HEX[13:7]), 32'(seg_tab[mval / 16]));
    endtask

    task automatic do_reset();
        #1 KEY[1] = 1'b0;
        mval = 0;
        mflg = 0;
        #2 KEY[1] = 1'b1;
        #1;
    endtask

    localparam logic [9:0] SHIFT = 10'b10_1000_0000;
    localparam logic [9:0] UP    = 10'b11_0000_0000;
    localparam logic [9:0] DOWN  = 10'b11_1000_0000;
    localparam logic [9:0] HOLD  = 10'b10_0000_0000;

    initial begin
        KEY = 2'b00;
        SW  = '0;
        #3;
        check("reset.ledr", 32'(LEDR), 32'h100);
        check("reset.hex", 32'(HEX), 32'b1000000_1000000);
        KEY[1] = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) pulse(UP);
        check_all("count3");
        #1 KEY[1] = 1'b0;
        mval = 0;
        mflg = 0;
        #1;
        check("async.ledr", 32'(LEDR), 32'h100);
        check("async.hex", 32'(HEX), 32'b1000000_1000000);
        pulse(UP);
        check("held_in_reset.ledr", 32'(LEDR), 32'h100);
        KEY[1] = 1'b1;
        #2;
        pulse(SHIFT | 10'h3);
        pulse(SHIFT | 10'hA);
        check("shift3a.val", 32'(LEDR), 32'h03A);
        check("shift3a.hex1", 32'(HEX[13:7]), 32'b0110000);
        check("shift3a.hex0", 32'(HEX[6:0]), 32'b0001000);
        pulse(SHIFT | 10'h5);
        check("shift5.ledr", 32'(LEDR), 32'h2A5);
        pulse(SHIFT | 10'hF);
        pulse(SHIFT | 10'hE);
        check_all("load_fe");
        for (int i = 0; i < 3; i++) begin
            pulse(UP);
            check_all($sformatf("up%0d", i));
        end
        pulse(DOWN);
        check_all("down_to0");
        pulse(DOWN);
        check_all("down_wrap");
        for (int i = 0; i < 5; i++) pulse(UP & 10'h1FF);
        check_all("disabled");
        for (int i = 0; i < 2; i++) pulse(HOLD);
        check_all("hold");
        pulse(SHIFT | 10'hF);
        pulse(SHIFT | 10'hF);
        pulse(UP);
        pulse(UP);
        check_all("up_at_ff");
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 40) == 0) do_reset();
            pulse(10'($urandom));
            check_all($sformatf("rnd%0d", i));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
